// File: rtl/pipe_skid_chain.sv
// pipe_skid_chain
//   Chain of DEPTH valid/ready register slices. Each slice holds a main
//   register (drives the slice output) and a skid register (catches the one
//   entry that arrives while main is stalled), so every slice's ready is a
//   plain flop output and there is no combinational ready path end to end.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset (wins over flush and handshakes)
//   flush      synchronous discard of every held entry
//   in_valid   upstream presents in_data
//   in_data    upstream payload [WIDTH-1:0]
//   in_ready   chain can accept this cycle (registered)
//   out_valid  out_data holds an entry
//   out_data   head-of-chain payload [WIDTH-1:0]
//   out_ready  downstream accepts this cycle
//   occupancy  number of valid entries held, 0..2*DEPTH
module pipe_skid_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [WIDTH-1:0]                 out_data,
  input  logic                             out_ready,
  output logic [$clog2(2*DEPTH+1)-1:0]     occupancy
);

  localparam int OCC_W = $clog2(2*DEPTH+1);

  logic [DEPTH-1:0] main_valid;
  logic [DEPTH-1:0] skid_valid;
  logic [WIDTH-1:0] main_data [DEPTH];
  logic [WIDTH-1:0] skid_data [DEPTH];

  // Per-slice upstream valid/data and downstream ready.
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data [DEPTH];
  logic [DEPTH-1:0] dn_ready;
  logic [DEPTH-1:0] accept;
  logic [DEPTH-1:0] pop;

  for (genvar g = 0; g < DEPTH; g++) begin : g_link
    if (g == 0) begin : g_head
      assign up_valid[g] = in_valid;
      assign up_data[g]  = in_data;
    end else begin : g_mid
      assign up_valid[g] = main_valid[g-1];
      assign up_data[g]  = main_data[g-1];
    end

    if (g == DEPTH-1) begin : g_tail
      assign dn_ready[g] = out_ready;
    end else begin : g_inner
      assign dn_ready[g] = ~skid_valid[g+1];
    end

    // Slice ready is simply "skid is empty".
    assign accept[g] = up_valid[g] & ~skid_valid[g];
    assign pop[g]    = main_valid[g] & dn_ready[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= '0;
      skid_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        main_data[i] <= '0;
        skid_data[i] <= '0;
      end
    end else if (flush) begin
      // Only valid bits drop; data registers keep their contents.
      main_valid <= '0;
      skid_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!main_valid[i] || pop[i]) begin
          // Skid entry is older than anything arriving now, so it goes first.
          // accept[i] is 0 whenever skid is valid, so nothing is lost.
          if (skid_valid[i]) begin
            main_data[i]  <= skid_data[i];
            main_valid[i] <= 1'b1;
          end else if (accept[i]) begin
            main_data[i]  <= up_data[i];
            main_valid[i] <= 1'b1;
          end else begin
            main_valid[i] <= 1'b0;
          end
          skid_valid[i] <= 1'b0;
        end else if (accept[i]) begin
          skid_data[i]  <= up_data[i];
          skid_valid[i] <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = ~skid_valid[0];
  assign out_valid = main_valid[DEPTH-1];
  assign out_data  = main_data[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(main_valid[i]) + OCC_W'(skid_valid[i]);
    end
  end

endmodule
